// File: rtl/vpi_word_fifo_pkg.sv
// Shared stream constants for the VPI word FIFO.
// The VPI C-side reader of level/drop_count/overflow uses the same values.
package vpi_word_fifo_pkg;

  localparam int VPI_DATA_W     = 32;
  localparam int VPI_FIFO_DEPTH = 16;
  localparam int VPI_FIFO_AW    = 4;
  localparam int VPI_CNT_W      = 16;

endpackage

// File: rtl/vpi_word_fifo_ram.sv
// DEPTH x DATA_W word storage for the VPI FIFO.
// Synchronous write, asynchronous read for the FWFT head.
module vpi_word_ram
  import vpi_word_fifo_pkg::*;
#(
  parameter int DATA_W = VPI_DATA_W,
  parameter int DEPTH  = VPI_FIFO_DEPTH,
  parameter int AW     = VPI_FIFO_AW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vpi_word_fifo.sv
// FWFT word FIFO behind the VPI data register.
// Tracks occupancy, high-water mark and saturating drop statistics.
module vpi_word_fifo
  import vpi_word_fifo_pkg::*;
#(
  parameter int DATA_W = VPI_DATA_W,
  parameter int DEPTH  = VPI_FIFO_DEPTH,
  parameter int AW     = VPI_FIFO_AW,
  parameter int CNT_W  = VPI_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic [AW:0]       high_water,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [AW:0]       hw_q, hw_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop, wen;
  logic [DATA_W-1:0] head;

  assign in_ready  = (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;
  assign wen       = push & ~flush;

  vpi_word_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wen),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
    hw_d = (level_d > hw_q) ? level_d : hw_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hw_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hw_q     <= hw_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Memory is never cleared, so mask the head while empty.
  assign out_data   = out_valid ? head : '0;
  assign level      = level_q;
  assign high_water = hw_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vpi_word_fifo.sv
// Self-checking bench for vpi_word_fifo.
// Queue scoreboard plus a small vector table and corner sequences.
module tb_vpi_word_fifo;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic        out_valid, out_ready, overflow;
  logic [31:0] in_data, out_data;
  logic [4:0]  level, high_water;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb_q [$];
  int          m_level = 0;
  int          m_hw    = 0;
  int          m_drop  = 0;
  bit          m_ovf   = 0;

  always #5 clk = ~clk;

  vpi_word_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .high_water (high_water),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(bit iv, logic [31:0] d, bit ordy,
                     bit fl = 0, bit rs = 0);
    bit push, pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    push = iv && (m_level != 16) && !fl;
    pop  = (m_level != 0) && ordy && !fl;
    if (rs) begin
      sb_q.delete();
      m_level = 0;
      m_hw    = 0;
      m_drop  = 0;
      m_ovf   = 0;
    end else if (fl) begin
      sb_q.delete();
      m_level = 0;
    end else begin
      if (iv && m_level == 16) begin
        m_ovf = 1;
        if (m_drop != 65535) m_drop++;
      end
      if (pop) begin
        chk("pop_data", out_data, sb_q.pop_front());
        m_level--;
      end
      if (push) begin
        sb_q.push_back(d);
        m_level++;
      end
      if (m_level > m_hw) m_hw = m_level;
    end
    @(posedge clk);
    #1;
    reset = 0;
    flush = 0;
    chk("level", level, m_level);
    chk("out_valid", out_valid, m_level != 0);
    chk("in_ready", in_ready, m_level != 16);
    chk("high_water", high_water, m_hw);
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
    if (m_level != 0) chk("head", out_data, sb_q[0]);
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          fl;
    int          e_level;
    bit          e_ovalid;
    logic [31:0] e_odata;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 32'h11, 0, 0, 1, 1, 32'h11};
    tbl[1] = '{1, 32'h22, 1, 0, 1, 1, 32'h22};
    tbl[2] = '{1, 32'h33, 0, 0, 2, 1, 32'h22};
    tbl[3] = '{0, 32'h0,  1, 0, 1, 1, 32'h33};
    tbl[4] = '{0, 32'h0,  1, 0, 0, 0, 32'h0};
    tbl[5] = '{1, 32'h44, 0, 1, 0, 0, 32'h0};
    tbl[6] = '{1, 32'h55, 0, 0, 1, 1, 32'h55};
    tbl[7] = '{0, 32'h0,  1, 0, 0, 0, 32'h0};

    reset = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    cyc(0, 0, 0, 0, 1);
    chk("rst_out_data", out_data, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_level", i), level, tbl[i].e_level);
      chk($sformatf("vec%0d_ovalid", i), out_valid, tbl[i].e_ovalid);
      chk($sformatf("vec%0d_odata", i), out_data, tbl[i].e_odata);
    end
    chk("vec_hw", high_water, 2);

    // Test 1: fill then drain
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) cyc(1, 32'(i), 0);
    chk("t1_level", level, 16);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_hw", high_water, 16);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("t1_empty", level, 0);

    // Test 2: drops while full
    for (int i = 0; i < 16; i++) cyc(1, 32'h100 + 32'(i), 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD0000 + 32'(i), 0);
    chk("t2_drop", drop_count, 3);
    chk("t2_ovf", overflow, 1);
    chk("t2_level", level, 16);
    chk("t2_head", out_data, 32'h100);

    // Test 3: level 5, push+pop for 10 cycles across the wrap
    for (int i = 0; i < 11; i++) cyc(0, 0, 1);
    chk("t3_level5", level, 5);
    for (int i = 0; i < 10; i++) cyc(1, 32'hA5A5A5A5, 1);
    chk("t3_level_kept", level, 5);

    // Test 4: full plus pop
    for (int i = 0; i < 11; i++) cyc(1, 32'h200 + 32'(i), 0);
    chk("t4_full", level, 16);
    cyc(1, 32'hBAD0BAD0, 1);
    chk("t4_level", level, 15);
    chk("t4_drop", drop_count, 4);

    // Test 5: flush with push at level 7
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("t5_level7", level, 7);
    cyc(1, 32'hF1F1F1F1, 0, 1);
    chk("t5_level", level, 0);
    chk("t5_ovalid", out_valid, 0);
    chk("t5_drop", drop_count, 4);
    chk("t5_hw", high_water, 16);

    // Test 6: reset at level 9 with overflow set
    for (int i = 0; i < 9; i++) cyc(1, 32'h300 + 32'(i), 0);
    chk("t6_level9", level, 9);
    chk("t6_ovf_set", overflow, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_level", level, 0);
    chk("t6_hw", high_water, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_odata", out_data, 0);
    chk("t6_in_ready", in_ready, 1);
    cyc(1, 32'h12345678, 0);
    chk("t6_push_data", out_data, 32'h12345678);
    cyc(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
